// File: rtl/stream_checker.sv
// Stream self-check endpoint: packets must start at expected_first and count up by one per beat (mod 256).
// Latency: pkt_count/err_count/last_len/err_pulse update one cycle after the accepting edge of the last beat.
// Backpressure: sink_ready is registered; with STREAM_CHECKER_BACKPRESSURE_EN it drops one cycle in four, else stays high.
module stream_checker #(
   parameter int MAX_LEN = 64
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        sink_valid,
   input  logic        sink_last,
   input  logic [7:0]  sink_data,
   output logic        sink_ready,
   input  logic [7:0]  expected_first,
   output logic [15:0] pkt_count,
   output logic [15:0] err_count,
   output logic [7:0]  last_len,
   output logic        err_pulse,
   output logic        busy
);

   typedef enum logic {IDLE = 1'b0, BODY = 1'b1} state_t;

   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

   state_t      state_q, state_d;
   logic [7:0]  expected_q, expected_d;
   logic [7:0]  beat_cnt_q, beat_cnt_d;
   logic        err_flag_q, err_flag_d;
   logic        cmpl_q, cmpl_d;
   logic        cmpl_err_q, cmpl_err_d;
   logic [7:0]  cmpl_len_q, cmpl_len_d;
   logic        ready_q, ready_d;
   logic [15:0] pkt_count_q, err_count_q;
   logic [7:0]  last_len_q;
   logic        err_pulse_q;

   logic        accept, first_beat, mismatch, len_err, err_now;
   logic [7:0]  cnt_next;

   assign accept     = sink_valid & ready_q;
   assign first_beat = (state_q == IDLE);
   // Compare against received-data + 1, so one bad byte flags the packet without cascading.
   assign mismatch   = sink_data != (first_beat ? expected_first : expected_q);
   assign len_err    = !first_beat && (beat_cnt_q == MAX_LEN_B);
   assign cnt_next   = first_beat ? 8'd1 : (len_err ? MAX_LEN_B : beat_cnt_q + 8'd1);
   assign err_now    = (err_flag_q & !first_beat) | mismatch | len_err;

`ifdef STREAM_CHECKER_BACKPRESSURE_EN
   logic [1:0] bp_cnt_q, bp_cnt_d;

   assign bp_cnt_d = bp_cnt_q + 2'd1;
   // Ready is low while the free-running counter sits at 3.
   assign ready_d  = (bp_cnt_d != 2'd3);

   always_ff @(posedge sys_clk) begin
      if (sys_rst) bp_cnt_q <= 2'd0;
      else         bp_cnt_q <= bp_cnt_d;
   end
`else
   assign ready_d = 1'b1;
`endif

   always_ff @(posedge sys_clk) begin
      if (sys_rst) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (accept) state_d = sink_last ? IDLE : BODY;
   end

   always_comb begin
      busy = (state_q == BODY);
   end

   always_comb begin
      expected_d = expected_q;
      beat_cnt_d = beat_cnt_q;
      err_flag_d = err_flag_q;
      cmpl_d     = 1'b0;
      cmpl_len_d = cmpl_len_q;
      cmpl_err_d = cmpl_err_q;
      if (accept) begin
         expected_d = sink_data + 8'd1;
         beat_cnt_d = cnt_next;
         err_flag_d = err_now;
         if (sink_last) begin
            cmpl_d     = 1'b1;
            cmpl_len_d = cnt_next;
            cmpl_err_d = err_now;
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         expected_q  <= 8'd0;
         beat_cnt_q  <= 8'd0;
         err_flag_q  <= 1'b0;
         cmpl_q      <= 1'b0;
         cmpl_len_q  <= 8'd0;
         cmpl_err_q  <= 1'b0;
         ready_q     <= 1'b0;
         pkt_count_q <= 16'd0;
         err_count_q <= 16'd0;
         last_len_q  <= 8'd0;
         err_pulse_q <= 1'b0;
      end else begin
         expected_q  <= expected_d;
         beat_cnt_q  <= beat_cnt_d;
         err_flag_q  <= err_flag_d;
         cmpl_q      <= cmpl_d;
         cmpl_len_q  <= cmpl_len_d;
         cmpl_err_q  <= cmpl_err_d;
         ready_q     <= ready_d;
         err_pulse_q <= cmpl_q & cmpl_err_q;
         if (cmpl_q) begin
            pkt_count_q <= pkt_count_q + 16'd1;
            last_len_q  <= cmpl_len_q;
            if (cmpl_err_q) err_count_q <= err_count_q + 16'd1;
         end
      end
   end

   assign sink_ready = ready_q;
   assign pkt_count  = pkt_count_q;
   assign err_count  = err_count_q;
   assign last_len   = last_len_q;
   assign err_pulse  = err_pulse_q;

endmodule
